// File: rtl/alu_ram_sequencer_pkg.sv
// Shared definitions for the ALU/RAM sequencer: default widths, FSM
// state encoding and the ALU opcode values carried on alu_sel.
package alu_ram_sequencer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_PASS_A = 4'd5;

endpackage

// File: rtl/alu_ram_sequencer_if.sv
// Bundle of control, ROM, ALU and RAM signals around the sequencer.
// master = the sequencer itself, slave = the surrounding ROM/ALU/RAM/host.
interface alu_ram_sequencer_if #(
    parameter int DATA_W = alu_ram_sequencer_pkg::DATA_W_DEF,
    parameter int ADDR_W = alu_ram_sequencer_pkg::ADDR_W_DEF
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [3:0]        alu_op;
    logic              en_ROM;
    logic [ADDR_W-1:0] addr_ROM;
    logic [DATA_W-1:0] d_op1;
    logic [DATA_W-1:0] d_op2;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_res;
    logic              we_RAM;
    logic [ADDR_W-1:0] addr_RAM;
    logic [DATA_W-1:0] din_RAM;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    modport master (
        input  start, abort, first_addr, last_addr, alu_op, d_op1, d_op2, alu_res,
        output en_ROM, addr_ROM, alu_a, alu_b, alu_sel, we_RAM, addr_RAM, din_RAM,
               busy, done, count
    );

    modport slave (
        output start, abort, first_addr, last_addr, alu_op, d_op1, d_op2, alu_res,
        input  en_ROM, addr_ROM, alu_a, alu_b, alu_sel, we_RAM, addr_RAM, din_RAM,
               busy, done, count
    );
endinterface

// File: rtl/alu_ram_sequencer_addr.sv
// Operand address counter: loads first/last on start, steps modulo 2^ADDR_W
// and flags when the current address is the terminal one.
module addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;

    always_comb begin
        addr_d = addr_q;
        last_d = last_q;
        if (load) begin
            addr_d = first_addr;
            last_d = last_addr;
        end else if (inc) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            last_q <= '0;
        end else begin
            addr_q <= addr_d;
            last_q <= last_d;
        end
    end

    assign addr    = addr_q;
    assign at_last = (addr_q == last_q);
endmodule

// File: rtl/alu_ram_sequencer.sv
// Walks an address range: fetch two ROM operands, run them through the
// external ALU, write the result to RAM; three cycles per element.
module alu_ram_sequencer
    import alu_ram_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_ram_sequencer_if.master  bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              cnt_load, cnt_inc, at_last;
    logic [ADDR_W-1:0] addr;
    logic              en_rom, we_ram, done_pulse;

    addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .first_addr (bus.first_addr),
        .last_addr  (bus.last_addr),
        .addr       (addr),
        .at_last    (at_last)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_d      = res_q;
        op_d       = op_q;
        count_d    = count_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        en_rom     = 1'b0;
        we_ram     = 1'b0;
        done_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    cnt_load = 1'b1;
                    op_d     = bus.alu_op;
                    count_d  = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                en_rom  = 1'b1;
                alu_a_d = bus.d_op1;
                alu_b_d = bus.d_op2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = bus.alu_res;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                we_ram  = 1'b1;
                count_d = count_q + 1'b1;
                if (at_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done_pulse = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the run: nothing further is written, counted or signalled.
        if (bus.abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            count_d    = count_q;
            cnt_inc    = 1'b0;
            we_ram     = 1'b0;
            done_pulse = 1'b0;
        end

        if (rst) begin
            en_rom     = 1'b0;
            we_ram     = 1'b0;
            done_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            alu_a_q <= '0;
            alu_b_q <= '0;
            res_q   <= '0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    assign bus.en_ROM   = en_rom;
    assign bus.addr_ROM = addr;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_sel  = op_q;
    assign bus.we_RAM   = we_ram;
    assign bus.addr_RAM = addr;
    assign bus.din_RAM  = res_q;
    assign bus.busy     = (state_q != ST_IDLE) && !rst;
    assign bus.done     = done_pulse;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_alu_ram_sequencer.sv
// Directed bench for alu_ram_sequencer with ROM/ALU models and a RAM write log.
module tb_alu_ram_sequencer;
    import alu_ram_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ram_sequencer_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    alu_ram_sequencer #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom1(input logic [3:0] a);
        return 32'h1111_0000 + 32'(a) * 32'h0101;
    endfunction

    function automatic logic [31:0] rom2(input logic [3:0] a);
        return 32'h0000_1000 + 32'(a) * 32'h0033;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_PASS_A: return a;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_res(input logic [3:0] op, input logic [3:0] a);
        return alu_model(op, rom1(a), rom2(a));
    endfunction

    assign bus.d_op1   = rom1(bus.addr_ROM);
    assign bus.d_op2   = rom2(bus.addr_ROM);
    assign bus.alu_res = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_n = 0;
    int done_cyc = 0;
    int busy_n = 0;
    logic [3:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.we_RAM === 1'b1) begin
            wr_addr.push_back(bus.addr_RAM);
            wr_data.push_back(bus.din_RAM);
            wr_cyc.push_back(cyc);
            $display("[TB] cyc %0d RAM write addr=%0d data=%08h", cyc, bus.addr_RAM, bus.din_RAM);
        end
        if (bus.done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus.busy === 1'b1) busy_n++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_n = 0;
        busy_n = 0;
    endtask

    task automatic pulse_start(input logic [3:0] first, input logic [3:0] last, input logic [3:0] op);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.first_addr = first;
        bus.last_addr = last;
        bus.alu_op = op;
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_idle_timeout"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic run_check(input string tag, input logic [3:0] first, input logic [3:0] last,
                             input logic [3:0] op, input int n);
        logic [3:0] a;
        clear_logs();
        pulse_start(first, last, op);
        wait_idle(tag);
        check({tag, "_writes"}, 64'(wr_addr.size()), 64'(n));
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            a = first + 4'(k);
            check($sformatf("%s_addr%0d", tag, k), 64'(wr_addr[k]), 64'(a));
            check($sformatf("%s_data%0d", tag, k), 64'(wr_data[k]), 64'(exp_res(op, a)));
            check($sformatf("%s_cyc%0d", tag, k), 64'(wr_cyc[k] - start_cyc), 64'(2 + 3 * k));
        end
        check({tag, "_done_n"}, 64'(done_n), 64'(1));
        check({tag, "_done_cyc"}, 64'(done_cyc - start_cyc), 64'(3 * n));
        check({tag, "_count"}, 64'(bus.count), 64'(n));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(3 * n + 1));
        $display("[TB] run %s first=%0d last=%0d op=%0d writes=%0d count=%0d",
                 tag, first, last, op, wr_addr.size(), bus.count);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.first_addr = '0;
        bus.last_addr = '0;
        bus.alu_op = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_during", 64'(bus.busy), 64'(0));
        check("rst_we_during", 64'(bus.we_RAM), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_en_rom", 64'(bus.en_ROM), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_alu_a", 64'(bus.alu_a), 64'(0));
        check("rst_alu_sel", 64'(bus.alu_sel), 64'(0));
        check("rst_din", 64'(bus.din_RAM), 64'(0));
        check("rst_addr_ram", 64'(bus.addr_RAM), 64'(0));

        // Basic run, with two hand-computed results
        run_check("add_0_3", 4'd0, 4'd3, OP_ADD, 4);
        if (wr_data.size() == 4) begin
            check("add_hand_d0", 64'(wr_data[0]), 64'h1111_1000);
            check("add_hand_d3", 64'(wr_data[3]), 64'h1111_139C);
        end
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_din", 64'(bus.din_RAM), 64'h1111_139C);
        check("idle_hold_count", 64'(bus.count), 64'(4));
        check("idle_en_rom", 64'(bus.en_ROM), 64'(0));

        run_check("sub_wrap", 4'd14, 4'd1, OP_SUB, 4);
        run_check("xor_single", 4'd5, 4'd5, OP_XOR, 1);
        run_check("or_full", 4'd0, 4'd15, OP_OR, 16);
        run_check("and_full_wrap", 4'd9, 4'd8, OP_AND, 16);

        // Abort during the second element's WRITE
        clear_logs();
        pulse_start(4'd0, 4'd5, OP_ADD);
        repeat (5) @(posedge clk);
        #1;
        check("abort_pre_we", 64'(bus.we_RAM), 64'(1));
        bus.abort = 1'b1;
        #1;
        check("abort_we_suppressed", 64'(bus.we_RAM), 64'(0));
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_count", 64'(bus.count), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        check("abort_writes", 64'(wr_addr.size()), 64'(1));
        check("abort_done_n", 64'(done_n), 64'(0));
        $display("[TB] abort run writes=%0d count=%0d", wr_addr.size(), bus.count);

        // start and abort together in IDLE: no run
        clear_logs();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("startabort_busy", 64'(bus.busy), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("startabort_writes", 64'(wr_addr.size()), 64'(0));
        $display("[TB] start+abort in idle busy=%0d", bus.busy);

        // Reset during EXEC of third element, with an ignored start mid-run
        clear_logs();
        pulse_start(4'd0, 4'd7, OP_SUB);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.first_addr = 4'd9;
        bus.last_addr = 4'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_busy_pre", 64'(bus.busy), 64'(1));
        check("rstmid_count_pre", 64'(bus.count), 64'(2));
        rst = 1'b1;
        #1;
        check("rstmid_busy_during", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_count", 64'(bus.count), 64'(0));
        check("rstmid_alu_a", 64'(bus.alu_a), 64'(0));
        check("rstmid_alu_b", 64'(bus.alu_b), 64'(0));
        check("rstmid_alu_sel", 64'(bus.alu_sel), 64'(0));
        check("rstmid_din", 64'(bus.din_RAM), 64'(0));
        check("rstmid_addr_rom", 64'(bus.addr_ROM), 64'(0));
        check("rstmid_en_rom", 64'(bus.en_ROM), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_writes", 64'(wr_addr.size()), 64'(2));
        if (wr_addr.size() >= 2) begin
            check("rstmid_addr0", 64'(wr_addr[0]), 64'(0));
            check("rstmid_addr1", 64'(wr_addr[1]), 64'(1));
        end
        check("rstmid_done_n", 64'(done_n), 64'(0));
        $display("[TB] reset mid-run writes=%0d busy=%0d", wr_addr.size(), bus.busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
